// File: rtl/groundhog_pkg.sv
// Shared constants, state encoding and small helpers for the 8-way
// round-robin mux arbiter.
package groundhog_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return 8'h01 << idx;
  endfunction

  // Beat counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set request bit scanning ptr, ptr+1, ...
// modulo 8.
module rr_pick8
  import groundhog_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    pick = 3'd0;
    any  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick = req[ptr + SEL_W'(i)] ? (ptr + SEL_W'(i)) : pick;
      any  = any | req[ptr + SEL_W'(i)];
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin burst arbiter driving the shared 8-way 16-bit datapath mux
// and forwarding the owner's stream over a valid/ready handshake.
module mux8_rr_arbiter
  import groundhog_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic [7:0]        last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  output logic [7:0]        in_ready,
  output logic [7:0]        grant,
  output logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

  state_e            state_r, state_n;
  logic [SEL_W-1:0]  sel_r, sel_n;
  logic [SEL_W-1:0]  ptr_r, ptr_n;
  logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_n;
  logic [7:0]        grant_r, grant_n;
  logic [SEL_W-1:0]  pick_s;
  logic              any_s;
  logic              xfer_s;
  logic              release_s;
  logic [CNT_W-1:0]  beat_inc_s;
  logic [DATA_W-1:0] mux_s;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s),
    .any  (any_s)
  );

  // Shared 8-way datapath mux driven by the registered select.
  always_comb begin
    case (sel_r)
      3'd0:    mux_s = a;
      3'd1:    mux_s = b;
      3'd2:    mux_s = c;
      3'd3:    mux_s = d;
      3'd4:    mux_s = e;
      3'd5:    mux_s = f;
      3'd6:    mux_s = g;
      3'd7:    mux_s = h;
      default: mux_s = '0;
    endcase
  end

  assign out_valid  = (state_r == BURST) & req[sel_r];
  assign xfer_s     = out_valid & out_ready;
  assign beat_inc_s = sat_inc(beat_cnt_r);
  // Withdrawal releases without a beat; last and burst limit need a transfer.
  assign release_s  = ~req[sel_r]
                    | (xfer_s & last[sel_r])
                    | (xfer_s & (MAX_BURST_C != 8'd0) & (beat_inc_s == MAX_BURST_C));

  // Next-state and next-register logic for the IDLE/BURST sequencer.
  always_comb begin
    state_n    = state_r;
    sel_n      = sel_r;
    ptr_n      = ptr_r;
    beat_cnt_n = beat_cnt_r;
    grant_n    = grant_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_n    = BURST;
          sel_n      = pick_s;
          beat_cnt_n = 8'd0;
          grant_n    = onehot8(pick_s);
        end else begin
          grant_n    = 8'd0;
        end
      end
      BURST: begin
        beat_cnt_n = xfer_s ? beat_inc_s : beat_cnt_r;
        if (release_s) begin
          state_n = IDLE;
          ptr_n   = sel_r + 3'd1;
          grant_n = 8'd0;
        end else begin
          state_n = BURST;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 8'd0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 3'd0;
      ptr_r      <= 3'd0;
      beat_cnt_r <= 8'd0;
      grant_r    <= 8'd0;
    end else begin
      state_r    <= state_n;
      sel_r      <= sel_n;
      ptr_r      <= ptr_n;
      beat_cnt_r <= beat_cnt_n;
      grant_r    <= grant_n;
    end
  end

  assign grant    = grant_r;
  assign sel      = sel_r;
  assign busy     = (state_r == BURST);
  assign in_ready = grant_r & {8{out_ready}};
  assign out      = out_valid ? mux_s : '0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a scoreboard of expected beats
// popped whenever a transfer is observed.
module tb_mux8_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  last;
  logic [15:0] dat [8];
  logic [7:0]  in_ready;
  logic [7:0]  grant;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] sb_q[$];

  mux8_rr_arbiter #(.MAX_BURST(4), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .a         (dat[0]),
    .b         (dat[1]),
    .c         (dat[2]),
    .d         (dat[3]),
    .e         (dat[4]),
    .f         (dat[5]),
    .g         (dat[6]),
    .h         (dat[7]),
    .in_ready  (in_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] idx, input logic [15:0] data);
    sb_q.push_back({idx, data});
  endtask

  // Every observed transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_unexpected: observed sel=%0d out=%0h expected no beat", sel, out);
      end else begin
        check("sb_beat", {13'd0, sel, out}, {13'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] oh;
    int idx;
    rst_n = 1'b0;
    req = 8'h00;
    last = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) dat[i] = 16'h1000 + 16'(i);
    #12;
    check("rst_grant", {24'd0, grant}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sel", {29'd0, sel}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Single burst from requester 3 ending on last
    req = 8'h08; dat[3] = 16'hA000; out_ready = 1'b1; #1;
    check("a_idle_grant", {24'd0, grant}, 32'd0);
    tick();
    check("a_grant", {24'd0, grant}, 32'h08);
    check("a_sel", {29'd0, sel}, 32'd3);
    check("a_busy", {31'd0, busy}, 32'd1);
    check("a_out0", {16'd0, out}, 32'hA000);
    push(3'd3, 16'hA000);
    tick(); dat[3] = 16'hA001; #1;
    check("a_out1", {16'd0, out}, 32'hA001);
    push(3'd3, 16'hA001);
    tick(); dat[3] = 16'hA002; last = 8'h08; #1;
    check("a_out2", {16'd0, out}, 32'hA002);
    push(3'd3, 16'hA002);
    tick();
    check("a_release", {24'd0, grant}, 32'd0);
    check("a_idle_busy", {31'd0, busy}, 32'd0);
    req = 8'h00; last = 8'h00;
    tick();

    // Round robin from ptr=4 with wrap, one-beat bursts
    dat[3] = 16'h1003; req = 8'hFF; last = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      idx = (4 + k) % 8;
      oh = 8'h01 << idx;
      tick();
      check("b_grant", {24'd0, grant}, {24'd0, oh});
      push(3'(idx), dat[idx]);
      tick();
      check("b_gap", {24'd0, grant}, 32'd0);
    end
    req = 8'h00; last = 8'h00;
    tick();

    // Backpressure on owner 2 (ptr=6 wraps to 2)
    req = 8'h04; out_ready = 1'b0; dat[2] = 16'hC0DE;
    tick();
    check("c_grant", {24'd0, grant}, 32'h04);
    for (int j = 0; j < 5; j++) begin
      check("c_valid", {31'd0, out_valid}, 32'd1);
      check("c_out", {16'd0, out}, 32'hC0DE);
      check("c_in_ready", {24'd0, in_ready}, 32'd0);
      check("c_hold", {24'd0, grant}, 32'h04);
      tick();
    end
    out_ready = 1'b1; last = 8'h04; push(3'd2, 16'hC0DE); #1;
    check("c_in_ready_on", {24'd0, in_ready}, 32'h04);
    tick();
    check("c_release", {24'd0, grant}, 32'd0);
    req = 8'h00; last = 8'h00;
    tick();

    // Forced release after 4 beats, re-grant to 5, then 6 next
    req = 8'h20;
    tick();
    for (int bb = 0; bb < 2; bb++) begin
      check("d_grant", {24'd0, grant}, 32'h20);
      if (bb == 1) req = 8'h60;
      for (int k = 0; k < 4; k++) begin
        dat[5] = 16'h5000 + 16'(bb * 4 + k); #1;
        check("d_owner", {24'd0, grant}, 32'h20);
        push(3'd5, dat[5]);
        tick();
      end
      check("d_release", {24'd0, grant}, 32'd0);
      tick();
    end
    check("d_next6", {24'd0, grant}, 32'h40);
    req = 8'h00; #1;
    check("d_withdraw", {31'd0, out_valid}, 32'd0);
    tick();
    check("d_idle", {24'd0, grant}, 32'd0);

    // Withdrawal by owner 1 mid-burst (ptr=7)
    req = 8'h02; dat[1] = 16'hB100;
    tick();
    check("e_grant", {24'd0, grant}, 32'h02);
    push(3'd1, 16'hB100);
    tick();
    req = 8'h00; #1;
    check("e_valid", {31'd0, out_valid}, 32'd0);
    check("e_out", {16'd0, out}, 32'd0);
    check("e_still_owner", {24'd0, grant}, 32'h02);
    tick();
    check("e_release", {24'd0, grant}, 32'd0);
    check("e_busy", {31'd0, busy}, 32'd0);
    req = 8'h06;
    tick();
    check("e_ptr2", {24'd0, grant}, 32'h04);
    check("e_sel2", {29'd0, sel}, 32'd2);

    // Asynchronous reset mid-burst
    out_ready = 1'b0; #1;
    rst_n = 1'b0; #1;
    check("r_grant", {24'd0, grant}, 32'd0);
    check("r_valid", {31'd0, out_valid}, 32'd0);
    check("r_sel", {29'd0, sel}, 32'd0);
    check("r_out", {16'd0, out}, 32'd0);
    check("r_in_ready", {24'd0, in_ready}, 32'd0);
    req = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("r_idle", {31'd0, busy}, 32'd0);
    req = 8'h81;
    tick();
    check("r_ptr0", {24'd0, grant}, 32'h01);
    req = 8'h00;
    tick();
    check("r_done", {24'd0, grant}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
